// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes and result-register occupancy states shared by alu and alu_arbiter.
package alu_pkg;
    typedef logic [3:0] alu_op_t;
    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_OR  = 4'b0001;
    localparam alu_op_t ALU_ADD = 4'b0010;
    localparam alu_op_t ALU_SUB = 4'b0011;
    localparam alu_op_t ALU_SLL = 4'b0100;
    localparam alu_op_t ALU_SRL = 4'b0101;
    localparam alu_op_t ALU_XOR = 4'b0110;
    localparam alu_op_t ALU_EQ  = 4'b1000;
    localparam alu_op_t ALU_NE  = 4'b1001;
    localparam alu_op_t ALU_LT  = 4'b1010;
    localparam alu_op_t ALU_GE  = 4'b1011;
    localparam alu_op_t ALU_SLT = 4'b1100;
    localparam alu_op_t ALU_ONE = 4'b1111;
    typedef enum logic {EMPTY, FULL} rsp_state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational ALU; compares yield 0/1, LT/GE are unsigned, SLT is signed, unused codes yield 0.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  alu_op_t               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);
    localparam int SH_W = $clog2(DATA_WIDTH);
    logic [SH_W-1:0] sh;
    assign sh = b[SH_W-1:0];
    always_comb begin
        y = '0;
        case (op)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_SLL: y = a << sh;
            ALU_SRL: y = a >> sh;
            ALU_XOR: y = a ^ b;
            ALU_EQ:  y = DATA_WIDTH'(a == b);
            ALU_NE:  y = DATA_WIDTH'(a != b);
            ALU_LT:  y = DATA_WIDTH'(a < b);
            ALU_GE:  y = DATA_WIDTH'(a >= b);
            ALU_SLT: y = DATA_WIDTH'($signed(a) < $signed(b));
            ALU_ONE: y = DATA_WIDTH'(1);
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among NUM_REQ valid/ready requesters behind a one-entry result register.
// ALU_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority (lowest index wins).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int  DATA_WIDTH    = 32,
    parameter int  OPCODE_LENGTH = 4,
    parameter int  NUM_REQ       = 2,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_b,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic [ID_W-1:0]                  rsp_id
);
    rsp_state_t state, state_nx;
    logic accept, found, hs;
    logic [ID_W-1:0] gnt;
    logic [DATA_WIDTH-1:0] alu_y;
    assign rsp_valid = state == FULL;
    assign accept    = rst_n & (~rsp_valid | rsp_ready);
    assign hs        = accept & found;
    assign req_ready = hs ? NUM_REQ'(1) << gnt : '0;
`ifdef ALU_ARB_RR_EN
    logic [ID_W-1:0] ptr;
    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= '0;
        else if (hs)
            ptr <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    end
`endif
    // Descending scan so the candidate nearest the search start is the last one written.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
`ifdef ALU_ARB_RR_EN
            if (req_valid[(int'(ptr) + i) % NUM_REQ]) begin
                found = 1'b1;
                gnt   = ID_W'((int'(ptr) + i) % NUM_REQ);
            end
`else
            if (req_valid[i]) begin
                found = 1'b1;
                gnt   = ID_W'(i);
            end
`endif
        end
    end
    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op (alu_op_t'(req_op[gnt*OPCODE_LENGTH +: OPCODE_LENGTH])),
        .a  (req_a[gnt*DATA_WIDTH +: DATA_WIDTH]),
        .b  (req_b[gnt*DATA_WIDTH +: DATA_WIDTH]),
        .y  (alu_y)
    );
    always_ff @(posedge clk) state <= !rst_n ? EMPTY : state_nx;
    always_comb state_nx = accept ? (found ? FULL : EMPTY) : state;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= '0;
        end else if (hs) begin
            rsp_data <= alu_y;
            rsp_id   <= gnt;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a cycle-level reference model.
module tb_alu_arbiter;
    import alu_pkg::*;
    localparam int DW = 32;
    localparam int OW = 4;
    localparam int NR = 2;
    localparam int IW = $clog2(NR);

    logic clk = 1'b0;
    logic rst_n;
    logic [NR-1:0] req_valid, req_ready;
    logic [NR*OW-1:0] req_op;
    logic [NR*DW-1:0] req_a, req_b;
    logic rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [IW-1:0] rsp_id;

    int n_vec = 0;
    int n_err = 0;
    logic m_valid;
    logic [DW-1:0] m_data;
    int m_id, m_ptr;
    logic [NR-1:0] seen_ready;

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int sh = int'(b % DW);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLL: return a << sh;
            ALU_SRL: return a >> sh;
            ALU_XOR: return a ^ b;
            ALU_EQ:  return (a == b) ? 1 : 0;
            ALU_NE:  return (a != b) ? 1 : 0;
            ALU_LT:  return (a < b) ? 1 : 0;
            ALU_GE:  return (a >= b) ? 1 : 0;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 1 : 0;
            ALU_ONE: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_grant(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++)
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_valid[i] = v;
        req_op[i*OW +: OW] = op;
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    // Inputs are set at posedge+1; this checks before the next edge and advances the model across it.
    task automatic cycle();
        logic acc;
        int g;
        logic [NR-1:0] er;
        #1;
        acc = rst_n && (!m_valid || rsp_ready);
        g = acc ? exp_grant(req_valid, m_ptr) : -1;
        er = (g >= 0) ? NR'(1) << g : '0;
        seen_ready = req_ready;
        check("req_ready", req_ready, er);
        check("rsp_valid", rsp_valid, m_valid);
        if (m_valid) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", rsp_id, m_id);
        end
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0;
        end else if (acc) begin
            m_valid = g >= 0;
            if (g >= 0) begin
                m_data = ref_alu(req_op[g*OW +: OW], req_a[g*DW +: DW], req_b[g*DW +: DW]);
                m_id = g;
`ifdef ALU_ARB_RR_EN
                m_ptr = (g + 1) % NR;
`endif
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        req_valid = '0;
        cycle();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 0;
        m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0;
        repeat (2) @(posedge clk);
        #1;
        // reset while FULL and stalled
        rst_n = 1; rsp_ready = 1;
        set_req(0, 1, ALU_ADD, 5, 7);
        cycle();
        rsp_ready = 0; rst_n = 0;
        set_req(1, 1, ALU_OR, 1, 2);
        cycle();
        check("t1_ready_rst", seen_ready, 0);
        check("t1_valid", rsp_valid, 0);
        check("t1_data", rsp_data, 0);
        check("t1_id", rsp_id, 0);
        rst_n = 1; req_valid = '0; rsp_ready = 1;
        // single op
        set_req(0, 1, ALU_ADD, 5, 7);
        cycle();
        check("t2_ready", seen_ready, 2'b01);
        req_valid = '0;
        check("t2_valid", rsp_valid, 1);
        check("t2_data", rsp_data, 12);
        check("t2_id", rsp_id, 0);
        // contention
        do_reset();
        rsp_ready = 1;
        set_req(0, 1, ALU_SUB, 10, 3);
        set_req(1, 1, ALU_XOR, 32'hF0, 32'h0F);
        for (int k = 0; k < 4; k++) begin
            cycle();
`ifdef ALU_ARB_RR_EN
            check("t4_ready", seen_ready, (k % 2) ? 2'b10 : 2'b01);
            check("t4_data", rsp_data, (k % 2) ? 32'hFF : 32'd7);
            check("t4_id", rsp_id, k % 2);
`else
            check("t3_ready", seen_ready, 2'b01);
            check("t3_data", rsp_data, 7);
            check("t3_id", rsp_id, 0);
`endif
        end
        // back-pressure
        req_valid = '0;
        set_req(0, 1, ALU_ADD, 5, 7);
        cycle();
        req_valid = '0;
        set_req(1, 1, ALU_ADD, 100, 23);
        rsp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t5_stall_ready", seen_ready, 0);
            check("t5_hold_data", rsp_data, 12);
            check("t5_hold_id", rsp_id, 0);
        end
        rsp_ready = 1;
        cycle();
        check("t5_pass_ready", seen_ready, 2'b10);
        check("t5_data", rsp_data, 123);
        check("t5_id", rsp_id, 1);
        // back-to-back stream and illegal op
        req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            set_req(1, 1, ALU_SLL, 1, k);
            cycle();
            check("t6_valid", rsp_valid, 1);
            check("t6_data", rsp_data, 32'd1 << k);
        end
        set_req(1, 1, 4'b0111, 32'h1234, 32'h5678);
        cycle();
        check("t6_illegal", rsp_data, 0);
        check("t6_illegal_id", rsp_id, 1);
        req_valid = '0;
        cycle();
        check("t6_drain", rsp_valid, 0);
        // randomized traffic honouring the requester stability rule
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++)
                if (seen_ready[i] || !req_valid[i])
                    set_req(i, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                            ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom),
                            ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom));
            rsp_ready = $urandom_range(0, 3) != 0;
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
